fx3_burst_scheduler: RTL and testbench
======================================

FX3_BURST_SCHEDULER -- requirements
Module: fx3_burst_scheduler

Interface
REQ-001 Parameter BURST_LEN, default 8192: words per FX3 DMA burst; legal range 4..65535.
REQ-002 Parameter WM_LAT, default 3: words still written after the watermark flag asserts; legal range 1..15, and WM_LAT < BURST_LEN.
REQ-003 clock  input  1  single clock for all logic; FX3 PCLK domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 runEnable  input  1  1 = capture streaming requested.
REQ-006 testMode  input  1  1 = send a 16-bit counter pattern instead of FIFO data.
REQ-007 fx3_th0Ready  input  1  FX3 thread 0 ready; 0 = ready, 1 = not ready.
REQ-008 fx3_th0Watermark  input  1  FX3 thread 0 watermark; 0 = watermark reached.
REQ-009 fifoData  input  16  show-ahead FIFO head word, valid when fifoEmpty = 0.
REQ-010 fifoEmpty  input  1  sample FIFO empty.
REQ-011 fifoAlmostEmpty  input  1  sample FIFO almost empty.
REQ-012 fifoFull  input  1  sample FIFO full.
REQ-013 fifoRead  output  1  combinational; pops the FIFO head this cycle.
REQ-014 fx3_nWrite  output  1  registered; 0 = fx3_databus holds a valid word this cycle.
REQ-015 fx3_databus  output  16  registered; word presented to the FX3.
REQ-016 burstCount  output  16  registered; count of completed bursts; wraps 0xFFFF -> 0x0000.
REQ-017 overflowFlag  output  1  registered; sticky, fifoFull seen while running.
REQ-018 state  output  2  current state: IDLE = 0, WAIT_READY = 1, WRITE = 2, DRAIN = 3.

Function
REQ-019 Definition: a word is issued in a cycle when the state is WRITE or DRAIN and either testMode = 1 or fifoEmpty = 0.
REQ-020 fifoRead SHALL equal (word issued) AND testMode = 0.
REQ-021 On the cycle after a word is issued, fx3_nWrite SHALL be 0 and fx3_databus SHALL hold that word; otherwise fx3_nWrite SHALL be 1 and fx3_databus SHALL hold its previous value.
REQ-022 The issued word SHALL be fifoData when testMode = 0, and the test counter value when testMode = 1.
REQ-023 The test counter SHALL increment by 1 per word issued in testMode, wrap 0xFFFF -> 0x0000, and persist across bursts.
REQ-024 A word counter (wordCnt) SHALL count words issued in the current burst and clear on burst end.
REQ-025 IDLE: go to WAIT_READY when runEnable = 1.
REQ-026 WAIT_READY: go to IDLE when runEnable = 0.
REQ-027 WAIT_READY: otherwise go to WRITE when fx3_th0Ready = 0 and (fifoAlmostEmpty = 0 or testMode = 1).
REQ-028 WRITE: if a word is issued with wordCnt = BURST_LEN-1, the burst ends.
REQ-029 WRITE: else if fx3_th0Watermark = 0, go to DRAIN and load drainCnt = WM_LAT; a word issued that same cycle is not counted against drainCnt.
REQ-030 DRAIN: drainCnt decrements per word issued; the burst ends when the word issued with drainCnt = 1 completes, or when the REQ-028 condition occurs, whichever is first.
REQ-031 Burst end: burstCount increments, wordCnt clears, and the next state is IDLE if runEnable = 0, else WAIT_READY.
REQ-032 runEnable falling during WRITE or DRAIN SHALL NOT abort the burst; the burst completes first (REQ-031).
REQ-033 FIFO underrun (fifoEmpty = 1, testMode = 0) in WRITE or DRAIN: no word issued, state and counters hold, fifoRead = 0.
REQ-034 testMode SHALL only be sampled in IDLE or WAIT_READY; its value is held for the whole burst.
REQ-035 overflowFlag SHALL set when fifoFull = 1 in any state other than IDLE, and SHALL clear only on reset.
REQ-036 fx3_th0Ready going to 1 mid-burst SHALL be ignored; only the watermark terminates a burst early.

Reset
REQ-037 With reset = 1 at a clock edge, the block SHALL enter IDLE (state = 0).
REQ-038 Reset values: fx3_nWrite = 1, fx3_databus = 0x0000, burstCount = 0, overflowFlag = 0.
REQ-039 Reset values: test counter = 0, wordCnt = 0, drainCnt = 0.
REQ-040 fifoRead SHALL be 0 while reset = 1; reset mid-burst abandons the burst without incrementing burstCount.

Verification (bench: BURST_LEN = 4, WM_LAT = 2)
REQ-041 Test burst: testMode = 1, runEnable = 1, fx3_th0Ready = 0, watermark = 1 -> fx3_nWrite low for exactly 4 consecutive cycles, data 0,1,2,3; burstCount = 1; state returns to WAIT_READY.
REQ-042 Watermark drain: BURST_LEN = 8, FIFO holding 0x0100 upward, fx3_th0Watermark = 0 after the 2nd word -> exactly 4 words (0x0100..0x0103) written, then WAIT_READY.
REQ-043 Underrun: fifoEmpty = 1 for 3 cycles after the 2nd word -> 3-cycle gap with fx3_nWrite = 1 and fifoRead = 0, then the remaining 2 words; burstCount = 1.
REQ-044 Graceful stop: runEnable = 0 after the 1st word -> burst completes (4 words), state goes to IDLE, burstCount = 1, no further writes.
REQ-045 Overflow and reset: fifoFull pulse in WAIT_READY -> overflowFlag = 1 and stays 1 after 100 cycles; reset mid-burst -> all REQ-038/039 values on the next cycle and burstCount = 0.

Source files
------------

// File: rtl/fx3_burst_scheduler.sv
// -----------------------------------------------------------------------------
// fx3_burst_scheduler
//
// Moves 16-bit words from a show-ahead sample FIFO to the FX3 slave FIFO
// thread 0, one fixed-length DMA burst at a time. Each burst ends after
// BURST_LEN words. It can also end early: after the FX3 lowers its watermark
// flag, WM_LAT more words are written and then the burst stops. In test mode
// a free-running 16-bit counter is sent instead of FIFO data.
//
// Handshake: a word is issued in any WRITE/DRAIN cycle where a source word
// is available. The source is always available in test mode; otherwise it
// is available when fifoEmpty = 0. In FIFO mode fifoRead pops that word in
// the same cycle. On the next cycle fx3_nWrite = 0 and fx3_databus holds
// the word. There is no back-pressure once a burst has started.
//
// Parameters
//   BURST_LEN  words per burst (4..65535)
//   WM_LAT     words written after the watermark asserts (1..15, < BURST_LEN)
//
// Ports
//   clock, reset           single clock, synchronous active-high reset
//   runEnable              capture streaming requested
//   testMode               send counter pattern (sampled only between bursts)
//   fx3_th0Ready           0 = FX3 thread 0 ready
//   fx3_th0Watermark       0 = FX3 thread 0 watermark reached
//   fifoData               FIFO head word (show-ahead)
//   fifoEmpty/AlmostEmpty/Full  FIFO status
//   fifoRead               combinational pop strobe
//   fx3_nWrite             registered, 0 = fx3_databus valid
//   fx3_databus            registered word to the FX3
//   burstCount             registered completed-burst counter (wraps)
//   overflowFlag           sticky fifoFull seen while not IDLE
//   state                  FSM state (IDLE=0, WAIT_READY=1, WRITE=2, DRAIN=3)
// -----------------------------------------------------------------------------
module fx3_burst_scheduler #(
    parameter int BURST_LEN = 8192,
    parameter int WM_LAT    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        runEnable,
    input  logic        testMode,
    input  logic        fx3_th0Ready,
    input  logic        fx3_th0Watermark,
    input  logic [15:0] fifoData,
    input  logic        fifoEmpty,
    input  logic        fifoAlmostEmpty,
    input  logic        fifoFull,
    output logic        fifoRead,
    output logic        fx3_nWrite,
    output logic [15:0] fx3_databus,
    output logic [15:0] burstCount,
    output logic        overflowFlag,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        WRITE      = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    localparam logic [15:0] LAST_WORD  = 16'(BURST_LEN - 1);
    localparam logic [3:0]  DRAIN_LOAD = 4'(WM_LAT);

    state_t      state_q;
    logic        mode_q;      // testMode frozen for the duration of a burst
    logic [15:0] test_cnt;
    logic [15:0] word_cnt;
    logic [3:0]  drain_cnt;

    logic        bursting;
    logic        word_issued;
    logic        last_word;
    logic        drain_done;
    logic        burst_end;
    logic [15:0] issue_word;

    always_comb begin
        bursting    = (state_q == WRITE) || (state_q == DRAIN);
        word_issued = bursting && (mode_q || !fifoEmpty);
        last_word   = (word_cnt == LAST_WORD);
        drain_done  = (state_q == DRAIN) && (drain_cnt == 4'd1);
        burst_end   = word_issued && (last_word || drain_done);
        issue_word  = mode_q ? test_cnt : fifoData;
    end

    // Pop strobe is masked by reset so a burst abandoned by reset never
    // consumes a FIFO word.
    assign fifoRead = word_issued && !mode_q && !reset;
    assign state    = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            test_cnt     <= 16'h0000;
            word_cnt     <= 16'h0000;
            drain_cnt    <= 4'd0;
            fx3_nWrite   <= 1'b1;
            fx3_databus  <= 16'h0000;
            burstCount   <= 16'h0000;
            overflowFlag <= 1'b0;
        end else begin
            // Output register: a word issued now is presented next cycle.
            fx3_nWrite <= !word_issued;
            if (word_issued) begin
                fx3_databus <= issue_word;
            end
            if (word_issued && mode_q) begin
                test_cnt <= test_cnt + 16'd1;
            end

            if (fifoFull && (state_q != IDLE)) begin
                overflowFlag <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    mode_q <= testMode;
                    if (runEnable) begin
                        state_q <= WAIT_READY;
                    end
                end

                WAIT_READY: begin
                    mode_q <= testMode;
                    if (!runEnable) begin
                        state_q <= IDLE;
                    end else if (!fx3_th0Ready && (!fifoAlmostEmpty || testMode)) begin
                        state_q <= WRITE;
                    end
                end

                WRITE, DRAIN: begin
                    // runEnable and fx3_th0Ready are deliberately ignored
                    // here. Once a burst starts it runs to completion.
                    if (burst_end) begin
                        burstCount <= burstCount + 16'd1;
                        word_cnt   <= 16'h0000;
                        drain_cnt  <= 4'd0;
                        state_q    <= runEnable ? WAIT_READY : IDLE;
                    end else begin
                        if (word_issued) begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                        if (state_q == WRITE) begin
                            // The watermark is an FX3-side event. It starts
                            // the drain window even if the FIFO is empty this
                            // cycle. A word issued in the same cycle does not
                            // consume a drain slot.
                            if (!fx3_th0Watermark) begin
                                state_q   <= DRAIN;
                                drain_cnt <= DRAIN_LOAD;
                            end
                        end else if (word_issued) begin
                            drain_cnt <= drain_cnt - 4'd1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx3_burst_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fx3_burst_scheduler
//
// Two instances share one stimulus set:
//   u_dut4  BURST_LEN = 4, WM_LAT = 2   (main scenarios)
//   u_dut8  BURST_LEN = 8, WM_LAT = 2   (watermark drain scenario)
// A behavioural show-ahead FIFO advances its head word whenever the selected
// instance pops it. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_fx3_burst_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        runEnable;
    logic        testMode;
    logic        fx3_th0Ready;
    logic        fx3_th0Watermark;
    logic [15:0] fifoData;
    logic        fifoEmpty;
    logic        fifoAlmostEmpty;
    logic        fifoFull;

    logic        rd4, nw4, of4;
    logic [15:0] db4, bc4;
    logic [1:0]  st4;
    logic        rd8, nw8, of8;
    logic [15:0] db8, bc8;
    logic [1:0]  st8;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int sel    = 0;   // 0: FIFO follows u_dut4 pops, 1: follows u_dut8

    always #5 clock = ~clock;

    fx3_burst_scheduler #(.BURST_LEN(4), .WM_LAT(2)) u_dut4 (
        .clock(clock), .reset(reset), .runEnable(runEnable), .testMode(testMode),
        .fx3_th0Ready(fx3_th0Ready), .fx3_th0Watermark(fx3_th0Watermark),
        .fifoData(fifoData), .fifoEmpty(fifoEmpty), .fifoAlmostEmpty(fifoAlmostEmpty),
        .fifoFull(fifoFull), .fifoRead(rd4), .fx3_nWrite(nw4), .fx3_databus(db4),
        .burstCount(bc4), .overflowFlag(of4), .state(st4)
    );

    fx3_burst_scheduler #(.BURST_LEN(8), .WM_LAT(2)) u_dut8 (
        .clock(clock), .reset(reset), .runEnable(runEnable), .testMode(testMode),
        .fx3_th0Ready(fx3_th0Ready), .fx3_th0Watermark(fx3_th0Watermark),
        .fifoData(fifoData), .fifoEmpty(fifoEmpty), .fifoAlmostEmpty(fifoAlmostEmpty),
        .fifoFull(fifoFull), .fifoRead(rd8), .fx3_nWrite(nw8), .fx3_databus(db8),
        .burstCount(bc8), .overflowFlag(of8), .state(st8)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One clock: let combinational pop settle, capture it, take the edge,
    // then advance the FIFO head if it was popped.
    task automatic step();
        logic pop;
        #1;
        pop = (sel == 1) ? rd8 : rd4;
        @(posedge clock);
        #1;
        if (pop) fifoData = fifoData + 16'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        runEnable        = 1'b0;
        testMode         = 1'b0;
        fx3_th0Ready     = 1'b1;
        fx3_th0Watermark = 1'b1;
        fifoData         = 16'h0000;
        fifoEmpty        = 1'b1;
        fifoAlmostEmpty  = 1'b1;
        fifoFull         = 1'b0;

        // ---- reset values ----
        step();
        step();
        #1;
        chk("rst_state", 16'(st4), 16'd0);
        chk("rst_nwrite", 16'(nw4), 16'd1);
        chk("rst_databus", db4, 16'h0000);
        chk("rst_burstcount", bc4, 16'h0000);
        chk("rst_overflow", 16'(of4), 16'd0);
        chk("rst_fiforead", 16'(rd4), 16'd0);
        reset = 1'b0;

        // ---- test-mode burst: 4 words 0..3 ----
        sel = 0;
        testMode = 1'b1; runEnable = 1'b1; fx3_th0Ready = 1'b0;
        step();
        chk("t1_wait_ready", 16'(st4), 16'd1);
        step();
        chk("t1_write_state", 16'(st4), 16'd2);
        chk("t1_no_word_yet", 16'(nw4), 16'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_nwrite", 16'(nw4), 16'd0);
            chk("t1_data", db4, 16'(i));
        end
        chk("t1_burstcount", bc4, 16'd1);
        chk("t1_back_wait_ready", 16'(st4), 16'd1);
        runEnable = 1'b0;
        step();
        chk("t1_nwrite_after", 16'(nw4), 16'd1);
        chk("t1_idle", 16'(st4), 16'd0);

        // ---- watermark drain on the 8-word instance ----
        sel = 1;
        do_reset();
        testMode = 1'b0; fifoData = 16'h0100; fifoEmpty = 1'b0; fifoAlmostEmpty = 1'b0;
        runEnable = 1'b1; fx3_th0Ready = 1'b0; fx3_th0Watermark = 1'b1;
        step();
        step();
        step();
        chk("t2_word0_nwrite", 16'(nw8), 16'd0);
        chk("t2_word0", db8, 16'h0100);
        fx3_th0Watermark = 1'b0;
        step();
        chk("t2_word1", db8, 16'h0101);
        chk("t2_drain_state", 16'(st8), 16'd3);
        step();
        chk("t2_word2", db8, 16'h0102);
        step();
        chk("t2_word3", db8, 16'h0103);
        chk("t2_burstcount", bc8, 16'd1);
        chk("t2_wait_ready", 16'(st8), 16'd1);
        runEnable = 1'b0; fx3_th0Watermark = 1'b1;
        step();
        chk("t2_nwrite_after", 16'(nw8), 16'd1);
        chk("t2_pop_count", fifoData, 16'h0104);

        // ---- FIFO underrun gap ----
        sel = 0;
        do_reset();
        testMode = 1'b0; fifoData = 16'h0200; fifoEmpty = 1'b0; fifoAlmostEmpty = 1'b0;
        runEnable = 1'b1; fx3_th0Ready = 1'b0; fx3_th0Watermark = 1'b1;
        step();
        step();
        step();
        chk("t3_word0", db4, 16'h0200);
        step();
        chk("t3_word1", db4, 16'h0201);
        fifoEmpty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_gap_fiforead", 16'(rd4), 16'd0);
            step();
            chk("t3_gap_nwrite", 16'(nw4), 16'd1);
            chk("t3_gap_state", 16'(st4), 16'd2);
        end
        fifoEmpty = 1'b0;
        step();
        chk("t3_word2_nwrite", 16'(nw4), 16'd0);
        chk("t3_word2", db4, 16'h0202);
        step();
        chk("t3_word3", db4, 16'h0203);
        chk("t3_burstcount", bc4, 16'd1);
        runEnable = 1'b0;
        step();
        chk("t3_idle", 16'(st4), 16'd0);

        // ---- graceful stop, then counter persistence across bursts ----
        do_reset();
        testMode = 1'b1; fifoEmpty = 1'b1; fifoAlmostEmpty = 1'b1;
        runEnable = 1'b1; fx3_th0Ready = 1'b0;
        step();
        step();
        step();
        chk("t4_word0", db4, 16'h0000);
        runEnable = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("t4_nwrite", 16'(nw4), 16'd0);
            chk("t4_data", db4, 16'(i));
        end
        chk("t4_idle", 16'(st4), 16'd0);
        chk("t4_burstcount", bc4, 16'd1);
        step();
        step();
        chk("t4_no_more_writes", 16'(nw4), 16'd1);
        chk("t4_still_idle", 16'(st4), 16'd0);
        runEnable = 1'b1;
        step();
        step();
        step();
        chk("t4_counter_persists", db4, 16'h0004);
        runEnable = 1'b0;
        step();
        step();
        step();
        chk("t4_second_last", db4, 16'h0007);
        chk("t4_second_count", bc4, 16'd2);
        chk("t4_second_idle", 16'(st4), 16'd0);

        // ---- overflow flag ----
        do_reset();
        testMode = 1'b0; runEnable = 1'b0; fx3_th0Ready = 1'b1; fifoFull = 1'b1;
        step();
        chk("t5_no_ovf_idle", 16'(of4), 16'd0);
        fifoFull = 1'b0; runEnable = 1'b1;
        step();
        chk("t5_wait_ready", 16'(st4), 16'd1);
        fifoFull = 1'b1;
        step();
        fifoFull = 1'b0;
        chk("t5_ovf_set", 16'(of4), 16'd1);
        repeat (100) step();
        chk("t5_ovf_sticky", 16'(of4), 16'd1);
        chk("t5_still_waiting", 16'(st4), 16'd1);

        // ---- reset mid-burst (FIFO mode) ----
        fifoData = 16'h0300; fifoEmpty = 1'b0; fifoAlmostEmpty = 1'b0; fx3_th0Ready = 1'b0;
        step();
        step();
        step();
        chk("t5_mid_word1", db4, 16'h0301);
        reset = 1'b1;
        #1;
        chk("t5_fiforead_in_reset", 16'(rd4), 16'd0);
        step();
        chk("t5_rst_state", 16'(st4), 16'd0);
        chk("t5_rst_nwrite", 16'(nw4), 16'd1);
        chk("t5_rst_databus", db4, 16'h0000);
        chk("t5_rst_burstcount", bc4, 16'h0000);
        chk("t5_rst_overflow", 16'(of4), 16'd0);

        // ---- reset mid test-mode burst clears test and word counters ----
        testMode = 1'b1;
        reset = 1'b0;
        step();
        step();
        step();
        step();
        chk("t6_pre_word1", db4, 16'h0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_data", db4, 16'(i));
        end
        chk("t6_burstcount", bc4, 16'd1);
        chk("t6_wait_ready", 16'(st4), 16'd1);
        runEnable = 1'b0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
